// File: rtl/intc_nch.sv
// Multi-channel interrupt controller: edge-detected done strobes, maskable
// pending bits, IRQ/IACK handshake. Define INTC_ROUND_ROBIN_EN for round-robin arbitration.
module intc_nch #(
  parameter int unsigned NUM_CH    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic              IACK,
  input  logic [31:0]       input_addr,
  input  logic              write_enable,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              IRQ,
  output logic [31:0]       isr_addr,
  output logic              error
);

  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef logic [IDW-1:0] id_t;
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t            state, state_nx;
  logic [31:0]       isr_tab [NUM_CH];
  logic [NUM_CH-1:0] mask, pending, pend_nx, done_q, rise, eligible;
  id_t               id, win, isr_sel;
  logic              win_vld;
  logic [31:0]       offset;
  logic              in_win, isr_hit, mask_hit, pend_hit, insv_hit, bad_wr;

  // Addresses below BASE_ADDR wrap to a large offset and fall outside the window.
  assign offset   = input_addr - BASE_ADDR;
  assign in_win   = (offset[31:8] == 24'd0);
  assign isr_hit  = in_win && (offset[1:0] == 2'b00) && (offset[7:6] == 2'b00) &&
                    (32'(offset[5:2]) < NUM_CH);
  assign isr_sel  = IDW'(offset[5:2]);
  assign mask_hit = in_win && (offset[7:0] == 8'h40);
  assign pend_hit = in_win && (offset[7:0] == 8'h44);
  assign insv_hit = in_win && (offset[7:0] == 8'h48);
  assign bad_wr   = write_enable && in_win && !isr_hit && !mask_hit;

  assign rise     = done & ~done_q;
  assign eligible = pending & mask;

  always_comb begin
    read_data = '0;
    if (isr_hit) begin
      read_data = isr_tab[isr_sel];
    end else if (mask_hit) begin
      read_data[NUM_CH-1:0] = mask;
    end else if (pend_hit) begin
      read_data[NUM_CH-1:0] = pending;
    end else if (insv_hit) begin
      read_data[31]  = (state != IDLE);
      read_data[3:0] = 4'(id);
    end
  end

`ifdef INTC_ROUND_ROBIN_EN
  id_t ptr;

  always_comb begin
    int unsigned c;
    c       = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      c = (32'(ptr) + 32'd1 + k) % NUM_CH;
      if (!win_vld && eligible[id_t'(c)]) begin
        win_vld = 1'b1;
        win     = id_t'(c);
      end
    end
  end

  // Reset value NUM_CH-1 makes channel 0 the first search candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= id_t'(NUM_CH - 1);
    end else if (state == IDLE && win_vld) begin
      ptr <= win;
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!win_vld && eligible[id_t'(k)]) begin
        win_vld = 1'b1;
        win     = id_t'(k);
      end
    end
  end
`endif

  // A new done edge on the channel being acknowledged re-arms it.
  always_comb begin
    pend_nx = pending;
    if (state == REQ && IACK) pend_nx[id] = 1'b0;
    pend_nx = pend_nx | rise;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_vld) state_nx = REQ;
      REQ:     if (IACK)    state_nx = ACK;
      ACK:     if (!IACK)   state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      isr_tab  <= '{default: '0};
      mask     <= '1;
      pending  <= '0;
      done_q   <= '0;
      id       <= '0;
      IRQ      <= 1'b0;
      isr_addr <= '0;
      error    <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= done;
      pending <= pend_nx;
      error   <= bad_wr || (|(rise & pending));
      if (write_enable && isr_hit)  isr_tab[isr_sel] <= write_data;
      if (write_enable && mask_hit) mask <= write_data[NUM_CH-1:0];
      case (state)
        IDLE: if (win_vld) begin
          id       <= win;
          isr_addr <= isr_tab[win];
          IRQ      <= 1'b1;
        end
        REQ:  if (IACK) IRQ <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
